// File: rtl/pipelined_addsub.sv
// -----------------------------------------------------------------------------
// pipelined_addsub
//
// Purpose:
//   Two's-complement add/subtract unit. The carry chain is split into STAGES
//   equal slices with one register boundary per slice, so wide operands still
//   close timing. A valid/ready handshake on both sides lets the unit drop into
//   any streaming datapath. Results come out in acceptance order, and up to
//   STAGES beats are held while the consumer stalls.
//
// Parameters:
//   WIDTH   operand/result width, >= 2, must be a multiple of STAGES
//   STAGES  pipeline depth = number of carry slices, >= 1
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand beat present
//   in_ready   unit can accept a beat this cycle
//   a, b       operands
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0: a+b+cin, 1: a-b-cin
//   sat        (only with ADDSUB_SATURATE_EN) clamp result on signed overflow
//   out_valid  result beat present
//   out_ready  consumer accepts the result this cycle
//   sum        result, wrapped mod 2^WIDTH (or clamped when saturating)
//   cout       raw carry out of the adder MSB (sub: 1 = no borrow)
//   overflow   signed overflow of the operation (on the unsaturated sum)
//
// Configuration:
//   Define ADDSUB_SATURATE_EN to add the `sat` input and the clamping logic.
//   Without it the result always wraps.
// -----------------------------------------------------------------------------
module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef ADDSUB_SATURATE_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int SW = WIDTH / STAGES;

  // Refuse to build a pipeline whose slices would not tile the word exactly.
  if ((WIDTH < 2) || (STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_paramCheck
    $error("pipelined_addsub: WIDTH must be >= 2 and a multiple of STAGES >= 1");
  end

  // Per-stage inputs. Index k holds what stage k consumes this cycle: the
  // ports for stage 0, and the registers of stage k-1 otherwise.
  logic [WIDTH-1:0] w_aIn   [STAGES];
  logic [WIDTH-1:0] w_bIn   [STAGES];
  logic [WIDTH-1:0] w_sumIn [STAGES];
  logic             w_cIn   [STAGES];
  logic             w_validIn [STAGES];
`ifdef ADDSUB_SATURATE_EN
  logic             w_satIn [STAGES];
`endif

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] w_ready;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_ovf;

  // Subtraction is folded into the adder here: invert b and the carry-in once,
  // and every slice after this point just adds.
  assign w_aIn[0]     = a;
  assign w_bIn[0]     = sub ? ~b : b;
  assign w_cIn[0]     = sub ? ~cin : cin;
  assign w_sumIn[0]   = '0;
  assign w_validIn[0] = in_valid;
`ifdef ADDSUB_SATURATE_EN
  assign w_satIn[0]   = sat;
`endif

  // Stage k may load when some stage from k up to the output has a free slot,
  // or when the consumer is draining the output. This is the closed form of
  // "empty or downstream advancing", so there is no ripple through a chain.
  for (genvar k = 0; k < STAGES; k++) begin : g_ready
    assign w_ready[k] = out_ready | ~(&r_valid[STAGES-1:k]);
  end

  assign in_ready  = w_ready[0];
  assign out_valid = r_valid[STAGES-1];
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign overflow  = r_ovf;

  // Valid bits shift forward whenever their stage can load. Bubbles move
  // forward the same way, so a stage that loads from an empty predecessor
  // becomes empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      if (w_ready[0]) r_valid[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        if (w_ready[k]) r_valid[k] <= r_valid[k-1];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW:0]      w_slice;
    logic [WIDTH-1:0] w_sumNext;
    logic             w_load;

    // Data registers load only on a real beat. Idle operand values, which may
    // be X, never get into the pipe.
    assign w_load  = w_ready[k] & w_validIn[k];
    assign w_slice = {1'b0, w_aIn[k][k*SW +: SW]} + {1'b0, w_bIn[k][k*SW +: SW]}
                     + {{SW{1'b0}}, w_cIn[k]};

    // Insert this slice's result into the partial sum built by earlier stages.
    always_comb begin
      w_sumNext = w_sumIn[k];
      w_sumNext[k*SW +: SW] = w_slice[SW-1:0];
    end

    if (k < STAGES-1) begin : g_mid
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;
      logic [WIDTH-1:0] r_part;
      logic             r_carry;
`ifdef ADDSUB_SATURATE_EN
      logic             r_sat;
`endif

      // Skewed pipeline register. The operands ride along so that later
      // stages can add their upper slices. The finished lower sum bits and
      // this slice's carry move forward with them.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_a     <= '0;
          r_b     <= '0;
          r_part  <= '0;
          r_carry <= 1'b0;
`ifdef ADDSUB_SATURATE_EN
          r_sat   <= 1'b0;
`endif
        end else if (w_load) begin
          r_a     <= w_aIn[k];
          r_b     <= w_bIn[k];
          r_part  <= w_sumNext;
          r_carry <= w_slice[SW];
`ifdef ADDSUB_SATURATE_EN
          r_sat   <= w_satIn[k];
`endif
        end
      end

      assign w_aIn[k+1]     = r_a;
      assign w_bIn[k+1]     = r_b;
      assign w_sumIn[k+1]   = r_part;
      assign w_cIn[k+1]     = r_carry;
      assign w_validIn[k+1] = r_valid[k];
`ifdef ADDSUB_SATURATE_EN
      assign w_satIn[k+1]   = r_sat;
`endif
    end else begin : g_last
      logic [WIDTH-1:0] w_sumFinal;
      logic             w_ovf;

      // Signed overflow: both addends have the same sign (after the b
      // inversion for subtract), but the raw sum has the other sign.
      assign w_ovf = (w_aIn[k][WIDTH-1] == w_bIn[k][WIDTH-1]) &&
                     (w_sumNext[WIDTH-1] != w_aIn[k][WIDTH-1]);

      // On a saturating overflow, clamp toward the sign of a. Overflow is only
      // possible when a and b' share that sign.
      always_comb begin
        w_sumFinal = w_sumNext;
`ifdef ADDSUB_SATURATE_EN
        if (w_satIn[k] && w_ovf) begin
          w_sumFinal = w_aIn[k][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
      end

      // Output registers. They change only when a valid beat moves in, so a
      // stalled result stays steady for the consumer.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sum  <= '0;
          r_cout <= 1'b0;
          r_ovf  <= 1'b0;
        end else if (w_load) begin
          r_sum  <= w_sumFinal;
          r_cout <= w_slice[SW];
          r_ovf  <= w_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// -----------------------------------------------------------------------------
// tb_pipelined_addsub
//
// Testbench for pipelined_addsub at WIDTH=16, STAGES=2. A scoreboard queue
// holds the expected results in acceptance order. An arithmetic model built
// on signed/unsigned integers fills it whenever a beat is accepted, and each
// result the DUT hands over is popped and compared.
// -----------------------------------------------------------------------------
module tb_pipelined_addsub;

  typedef struct packed {
    logic        ovf;
    logic        cout;
    logic [15:0] sum;
  } expT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [15:0] opA = '0;
  logic [15:0] opB = '0;
  logic        cinIn = 1'b0;
  logic        subIn = 1'b0;
  logic        satIn = 1'b0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [15:0] sumOut;
  logic        coutOut;
  logic        ovfOut;

  int  checkCount = 0;
  int  errorCount = 0;
  int  stallCycles = 0;
  bit  randDone = 1'b0;
  expT expQ [$];

`ifdef ADDSUB_SATURATE_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  pipelined_addsub #(.WIDTH(16), .STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .a         (opA),
    .b         (opB),
    .cin       (cinIn),
    .sub       (subIn),
`ifdef ADDSUB_SATURATE_EN
    .sat       (satIn),
`endif
    .out_valid (outValid),
    .out_ready (outReady),
    .sum       (sumOut),
    .cout      (coutOut),
    .overflow  (ovfOut)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Count one comparison, and report it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model built on plain integer arithmetic. It does not use the
  // inverted-b adder form.
  function automatic expT model(input logic [15:0] ma, input logic [15:0] mb,
                                input logic mc, input logic ms, input logic msat);
    int  ua = int'(ma);
    int  ub = int'(mb);
    int  sa = int'($signed(ma));
    int  sb = int'($signed(mb));
    int  r;
    int  sr;
    expT e;
    if (!ms) begin
      r      = ua + ub + int'(mc);
      sr     = sa + sb + int'(mc);
      e.cout = (r > 65535);
    end else begin
      r      = ua - ub - int'(mc);
      sr     = sa - sb - int'(mc);
      e.cout = (r >= 0);
    end
    e.sum = r[15:0];
    e.ovf = (sr > 32767) || (sr < -32768);
    if (msat && e.ovf) e.sum = (sr > 0) ? 16'h7FFF : 16'h8000;
    return e;
  endfunction

  // Scoreboard. Handshakes are sampled at the falling edge, where they are
  // stable until the rising edge that performs the transfer. A reset pending
  // on that edge flushes every in-flight expectation.
  always @(negedge clk) begin
    expT e;
    if (rst) begin
      expQ.delete();
    end else begin
      if (outValid) begin
        if (expQ.size() == 0) begin
          checkOutput("spuriousOut", 32'(outValid), 32'd0);
        end else begin
          e = expQ[0];
          checkOutput("sum", 32'(sumOut), 32'(e.sum));
          checkOutput("cout", 32'(coutOut), 32'(e.cout));
          checkOutput("ovf", 32'(ovfOut), 32'(e.ovf));
          if (outReady) void'(expQ.pop_front());
        end
      end
      if (inValid && inReady) expQ.push_back(model(opA, opB, cinIn, subIn, SatEn && satIn));
    end
  end

  // Offer one beat starting just after a rising edge, and hold it until it is
  // accepted. The wait is bounded.
  task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tbv,
                               input logic tc, input logic ts, input logic tsat);
    bit accepted = 1'b0;
    inValid = 1'b1;
    opA = ta; opB = tbv; cinIn = tc; subIn = ts; satIn = tsat;
    for (int n = 0; n < 200 && !accepted; n++) begin
      @(negedge clk);
      accepted = inReady;
      if (!accepted) stallCycles++;
      @(posedge clk);
      #1;
    end
    if (!accepted) checkOutput("acceptTimeout", 32'd0, 32'd1);
    inValid = 1'b0;
    opA = 16'($urandom); opB = 16'($urandom);
    cinIn = 1'($urandom); subIn = 1'($urandom); satIn = 1'($urandom);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rstOutValid", 32'(outValid), 32'd0);
    checkOutput("rstSum", 32'(sumOut), 32'd0);
    checkOutput("rstCout", 32'(coutOut), 32'd0);
    checkOutput("rstOvf", 32'(ovfOut), 32'd0);
    checkOutput("rstInReady", 32'(inReady), 32'd1);

    // Latency: a beat accepted on one edge shows up after the second edge.
    @(posedge clk); #1;
    outReady = 1'b1;
    opA = 16'h7FFF; opB = 16'h0001; cinIn = 1'b0; subIn = 1'b0; satIn = 1'b0;
    inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    @(negedge clk);
    checkOutput("latEdge1Valid", 32'(outValid), 32'd0);
    @(negedge clk);
    checkOutput("latEdge2Valid", 32'(outValid), 32'd1);
    @(posedge clk); #1;

    // Directed arithmetic, streamed back to back. The stream must see no stalls.
    stallCycles = 0;
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
    applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
    applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
    checkOutput("streamStalls", 32'(stallCycles), 32'd0);
    repeat (3) @(posedge clk); #1;

    // Backpressure: two beats fill the pipe, and the input side must then close.
    outReady = 1'b0;
    applyStimulus(16'd1, 16'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'd2, 16'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("fullInReady", 32'(inReady), 32'd0);
    checkOutput("fullHeadSum", 32'(sumOut), 32'd1);
    @(posedge clk); #1;
    fork
      begin
        applyStimulus(16'd3, 16'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'd4, 16'd0, 1'b0, 1'b0, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 outReady = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;
    checkOutput("drainBackpressure", 32'(expQ.size()), 32'd0);

    // Reset mid-stream: two beats in flight are discarded.
    outReady = 1'b0;
    applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h4321, 16'h0101, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midRstOutValid", 32'(outValid), 32'd0);
    checkOutput("midRstSum", 32'(sumOut), 32'd0);
    checkOutput("midRstCout", 32'(coutOut), 32'd0);
    checkOutput("midRstOvf", 32'(ovfOut), 32'd0);
    checkOutput("midRstInReady", 32'(inReady), 32'd1);
    @(posedge clk); #1;
    outReady = 1'b1;
    repeat (6) @(posedge clk); #1;

    // Random traffic with random gaps and random consumer stalls.
    fork
      begin
        for (int i = 0; i < 1500; i++) begin
          if ($urandom_range(3) == 0) begin
            @(posedge clk); #1;
          end
          applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          outReady = ($urandom_range(2) != 0);
          @(posedge clk); #1;
        end
        outReady = 1'b1;
      end
    join

    for (int n = 0; n < 200 && expQ.size() != 0; n++) @(posedge clk);
    checkOutput("finalDrain", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
